tas_avg_gen: RTL and testbench

Parametrised next-generation temperature averaging system on a single 50 MHz domain.
- Deserialises the LSB-first serial stream into DATA_W-bit words.
- Hunts for a valid header word, then accumulates NUM_SAMPLES sample words and computes their truncated average.
- Writes the average to an external RAM with a one-cycle active-low strobe; the address decrements and wraps.
- Removes the old two-clock handshake and adds packet-abort detection with an error pulse.

---
 rtl/tas_pkg.sv | 23 ++
 rtl/tas_avg_gen_if.sv | 26 ++
 rtl/tas_ser2par.sv | 61 ++++++
 rtl/tas_avg_gen.sv | 139 +++++++++++++
 tb/tb_tas_avg_gen.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tas_pkg.sv
// tas_pkg: shared types and constants for the temperature averaging block.
//   state_t   - packet FSM state encoding
//   TAS_HDR0  - default first accepted header word
//   TAS_HDR1  - default second accepted header word
//   acc_width - accumulator width that cannot overflow for a full packet
package tas_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ACCUM = 2'd1,
        CHECK = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [15:0] TAS_HDR0 = 16'h00A5;
    localparam logic [15:0] TAS_HDR1 = 16'h00C3;

    // Sum of 2**log2_samples words of data_w bits needs log2_samples extra bits.
    function automatic int acc_width(input int data_w, input int log2_samples);
        return data_w + log2_samples;
    endfunction

endpackage

// File: rtl/tas_avg_gen_if.sv
// tas_avg_gen_if: serial input stream and RAM write port of tas_avg_gen.
//   serial_data, data_ena - serial bit and its qualifier (into the block)
//   ram_wr_n, ram_data, ram_addr - RAM write strobe, data and address (out)
//   pkt_err - one-cycle packet abort pulse (out)
// master: stream source / RAM side.  slave: tas_avg_gen.
interface tas_avg_gen_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
);
    logic              serial_data;
    logic              data_ena;
    logic              ram_wr_n;
    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              pkt_err;

    modport master (
        output serial_data, data_ena,
        input  ram_wr_n, ram_data, ram_addr, pkt_err
    );

    modport slave (
        input  serial_data, data_ena,
        output ram_wr_n, ram_data, ram_addr, pkt_err
    );
endinterface

// File: rtl/tas_ser2par.sv
// tas_ser2par: LSB-first serial-to-parallel converter.
//   clk_50, reset_n      - clock and async active-low reset
//   serial_data/data_ena - serial bit and qualifier
//   word, word_vld       - completed word and its one-cycle valid pulse
//   drop                 - one-cycle pulse when a partial word is discarded
module tas_ser2par #(
    parameter int DATA_W = 8
) (
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic              serial_data,
    input  logic              data_ena,
    output logic [DATA_W-1:0] word,
    output logic              word_vld,
    output logic              drop
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              word_vld_q, word_vld_d;
    logic              drop_q, drop_d;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        word_vld_d = 1'b0;
        drop_d     = 1'b0;
        if (data_ena) begin
            shift_d[bit_cnt_q] = serial_data;
            if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
                bit_cnt_d  = '0;
                word_vld_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end else if (bit_cnt_q != '0) begin
            // Enable dropped mid-word: the partial word is abandoned.
            bit_cnt_d = '0;
            drop_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            word_vld_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            word_vld_q <= word_vld_d;
            drop_q     <= drop_d;
        end
    end

    assign word     = shift_q;
    assign word_vld = word_vld_q;
    assign drop     = drop_q;
endmodule

// File: rtl/tas_avg_gen.sv
// tas_avg_gen: hunts for a header word, averages the following
// 2**LOG2_SAMPLES sample words and writes the truncated average to RAM
// at a decrementing, wrapping address.
//   clk_50, reset_n - clock and async active-low reset
//   bus (slave)     - serial stream in, RAM write port and pkt_err out
// Optional feature macro TAS_CHECKSUM_EN: a checksum word (header plus
// samples, mod 2**DATA_W) must follow the samples before the write.
//
// state | meaning
// HUNT  | waiting for a header word, other words ignored
// ACCUM | summing sample words
// CHECK | waiting for and comparing the checksum word (TAS_CHECKSUM_EN)
// WRITE | one-cycle RAM strobe, address steps down afterwards
module tas_avg_gen
    import tas_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                LOG2_SAMPLES = 2,
    parameter int                ADDR_W       = 11,
    parameter logic [DATA_W-1:0] HDR0         = DATA_W'(TAS_HDR0),
    parameter logic [DATA_W-1:0] HDR1         = DATA_W'(TAS_HDR1)
) (
    input logic           clk_50,
    input logic           reset_n,
    tas_avg_gen_if.slave  bus
);
    localparam int ACC_W   = acc_width(DATA_W, LOG2_SAMPLES);
    localparam int SCNT_W  = LOG2_SAMPLES + 1;
    localparam int NUM_SMP = 1 << LOG2_SAMPLES;

    logic [DATA_W-1:0] word;
    logic              word_vld;
    logic              drop;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic [SCNT_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              pkt_err_q, pkt_err_d;

    tas_ser2par #(.DATA_W(DATA_W)) u_ser2par (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .serial_data (bus.serial_data),
        .data_ena    (bus.data_ena),
        .word        (word),
        .word_vld    (word_vld),
        .drop        (drop)
    );

    assign acc_sum = acc_q + ACC_W'(word);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        samp_cnt_d = samp_cnt_q;
        csum_d     = csum_q;
        ram_data_d = ram_data_q;
        ram_addr_d = ram_addr_q;
        pkt_err_d  = 1'b0;
        case (state_q)
            HUNT: begin
                if (word_vld && (word == HDR0 || word == HDR1)) begin
                    state_d    = ACCUM;
                    acc_d      = '0;
                    samp_cnt_d = '0;
                    csum_d     = word;
                end
            end
            ACCUM: begin
                if (drop) begin
                    state_d   = HUNT;
                    pkt_err_d = 1'b1;
                end else if (word_vld) begin
                    acc_d      = acc_sum;
                    samp_cnt_d = samp_cnt_q + SCNT_W'(1);
                    csum_d     = csum_q + word;
                    if (samp_cnt_q == SCNT_W'(NUM_SMP-1)) begin
`ifdef TAS_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d    = WRITE;
                        ram_data_d = DATA_W'(acc_sum >> LOG2_SAMPLES);
`endif
                    end
                end
            end
`ifdef TAS_CHECKSUM_EN
            CHECK: begin
                if (drop) begin
                    state_d   = HUNT;
                    pkt_err_d = 1'b1;
                end else if (word_vld) begin
                    if (word == csum_q) begin
                        state_d    = WRITE;
                        ram_data_d = DATA_W'(acc_q >> LOG2_SAMPLES);
                    end else begin
                        state_d   = HUNT;
                        pkt_err_d = 1'b1;
                    end
                end
            end
`endif
            WRITE: begin
                state_d = HUNT;
                // Natural modulo wrap takes 0 back to DEPTH-1.
                ram_addr_d = ram_addr_q - ADDR_W'(1);
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= HUNT;
            acc_q      <= '0;
            samp_cnt_q <= '0;
            csum_q     <= '0;
            ram_data_q <= '0;
            ram_addr_q <= '1;
            pkt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            samp_cnt_q <= samp_cnt_d;
            csum_q     <= csum_d;
            ram_data_q <= ram_data_d;
            ram_addr_q <= ram_addr_d;
            pkt_err_q  <= pkt_err_d;
        end
    end

    assign bus.ram_wr_n = (state_q != WRITE);
    assign bus.ram_data = ram_data_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.pkt_err  = pkt_err_q;
endmodule

// File: tb/tb_tas_avg_gen.sv
// tb_tas_avg_gen: directed bench for tas_avg_gen with three parameter sets:
//   inst 0 - defaults, inst 1 - ADDR_W=2, inst 2 - DATA_W=4, LOG2_SAMPLES=0.
module tb_tas_avg_gen;

    logic clk_50 = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk_50 = ~clk_50;

    tas_avg_gen_if #(.DATA_W(8), .ADDR_W(11)) bus0 ();
    tas_avg_gen_if #(.DATA_W(8), .ADDR_W(2))  bus1 ();
    tas_avg_gen_if #(.DATA_W(4), .ADDR_W(11)) bus2 ();

    tas_avg_gen u_dut0 (
        .clk_50  (clk_50),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    tas_avg_gen #(.ADDR_W(2)) u_dut1 (
        .clk_50  (clk_50),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    tas_avg_gen #(.DATA_W(4), .LOG2_SAMPLES(0), .HDR0(4'hA), .HDR1(4'h3)) u_dut2 (
        .clk_50  (clk_50),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    int n_checks = 0;
    int n_errors = 0;

    int          wr_cnt [3];
    int          err_cnt [3];
    logic [15:0] wr_d [3][32];
    logic [15:0] wr_a [3][32];
    logic [15:0] smp [4];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record every strobe and error pulse, sampled mid-cycle.
    always @(negedge clk_50) begin
        if (bus0.ram_wr_n == 1'b0) begin
            if (wr_cnt[0] < 32) begin
                wr_d[0][wr_cnt[0]] = 16'(bus0.ram_data);
                wr_a[0][wr_cnt[0]] = 16'(bus0.ram_addr);
            end
            wr_cnt[0]++;
        end
        if (bus1.ram_wr_n == 1'b0) begin
            if (wr_cnt[1] < 32) begin
                wr_d[1][wr_cnt[1]] = 16'(bus1.ram_data);
                wr_a[1][wr_cnt[1]] = 16'(bus1.ram_addr);
            end
            wr_cnt[1]++;
        end
        if (bus2.ram_wr_n == 1'b0) begin
            if (wr_cnt[2] < 32) begin
                wr_d[2][wr_cnt[2]] = 16'(bus2.ram_data);
                wr_a[2][wr_cnt[2]] = 16'(bus2.ram_addr);
            end
            wr_cnt[2]++;
        end
        if (bus0.pkt_err) err_cnt[0]++;
        if (bus1.pkt_err) err_cnt[1]++;
        if (bus2.pkt_err) err_cnt[2]++;
    end

    task automatic drive(input int inst, input logic sd, input logic de);
        case (inst)
            0: begin bus0.serial_data = sd; bus0.data_ena = de; end
            1: begin bus1.serial_data = sd; bus1.data_ena = de; end
            default: begin bus2.serial_data = sd; bus2.data_ena = de; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic send_word(input int inst, input int width, input logic [15:0] w);
        for (int i = 0; i < width; i++) begin
            drive(inst, w[i], 1'b1);
            tick();
        end
    endtask

    task automatic send_bits(input int inst, input int nbits, input logic [15:0] w);
        for (int i = 0; i < nbits; i++) begin
            drive(inst, w[i], 1'b1);
            tick();
        end
    endtask

    task automatic idle(input int inst, input int n);
        drive(inst, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    // Header plus n samples; the checksum word is appended when that build option is on.
    task automatic send_pkt(input int inst, input int width, input logic [15:0] hdr,
                            input logic [15:0] s [4], input int n);
        logic [15:0] sum;
        sum = hdr;
        send_word(inst, width, hdr);
        for (int i = 0; i < n; i++) begin
            send_word(inst, width, s[i]);
            sum = sum + s[i];
        end
`ifdef TAS_CHECKSUM_EN
        sum = sum & 16'((1 << width) - 1);
        send_word(inst, width, sum);
`endif
    endtask

    task automatic do_reset();
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0);
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int b, e;
        for (int i = 0; i < 3; i++) begin
            wr_cnt[i]  = 0;
            err_cnt[i] = 0;
        end
        do_reset();

        // Reset values.
        check_val("rst_wr_n", 32'(bus0.ram_wr_n), 32'h1);
        check_val("rst_data", 32'(bus0.ram_data), 32'h0);
        check_val("rst_addr", 32'(bus0.ram_addr), 32'h7FF);
        check_val("rst_err", 32'(bus0.pkt_err), 32'h0);
        check_val("rst_addr_a2", 32'(bus1.ram_addr), 32'h3);
        check_val("rst_data_w4", 32'(bus2.ram_data), 32'h0);

        // Basic packet with latency check: (10+20+30+40)/4 = 25.
        b = wr_cnt[0];
        smp = '{16'd10, 16'd20, 16'd30, 16'd40};
        send_pkt(0, 8, 16'hA5, smp, 4);
        check_val("lat_pre", 32'(bus0.ram_wr_n), 32'h1);
        tick();
        check_val("lat_wr", 32'(bus0.ram_wr_n), 32'h0);
        check_val("t1_data", 32'(bus0.ram_data), 32'h19);
        check_val("t1_addr", 32'(bus0.ram_addr), 32'h7FF);
        tick();
        check_val("t1_wr_end", 32'(bus0.ram_wr_n), 32'h1);
        check_val("t1_addr_dec", 32'(bus0.ram_addr), 32'h7FE);
        idle(0, 3);
        check_val("t1_nwr", 32'(wr_cnt[0] - b), 32'h1);

        // Non-header packet ignored, then C3 packet of FF.
        do_reset();
        b = wr_cnt[0];
        e = err_cnt[0];
        smp = '{16'd10, 16'd20, 16'd30, 16'd40};
        send_pkt(0, 8, 16'h5A, smp, 4);
        idle(0, 2);
        smp = '{16'hFF, 16'hFF, 16'hFF, 16'hFF};
        send_pkt(0, 8, 16'hC3, smp, 4);
        idle(0, 4);
        check_val("t2_nwr", 32'(wr_cnt[0] - b), 32'h1);
        check_val("t2_data", 32'(wr_d[0][b]), 32'hFF);
        check_val("t2_addr", 32'(wr_a[0][b]), 32'h7FF);
        check_val("t2_nerr", 32'(err_cnt[0] - e), 32'h0);

        // Address wrap on a 4-entry RAM.
        b = wr_cnt[1];
        smp = '{16'h04, 16'h04, 16'h04, 16'h04};
        for (int p = 0; p < 5; p++) begin
            send_pkt(1, 8, 16'hC3, smp, 4);
            idle(1, 2);
        end
        idle(1, 2);
        check_val("t3_nwr", 32'(wr_cnt[1] - b), 32'h5);
        for (int p = 0; p < 5; p++) begin
            logic [15:0] exp_a;
            exp_a = (p == 4) ? 16'd3 : 16'(3 - p);
            check_val($sformatf("t3_addr%0d", p), 32'(wr_a[1][b+p]), 32'(exp_a));
            check_val($sformatf("t3_data%0d", p), 32'(wr_d[1][b+p]), 32'h04);
        end

        // Mid-word drop inside a packet aborts it.
        do_reset();
        b = wr_cnt[0];
        e = err_cnt[0];
        send_word(0, 8, 16'hA5);
        send_word(0, 8, 16'd10);
        send_bits(0, 3, 16'd20);
        idle(0, 5);
        check_val("t4_nerr", 32'(err_cnt[0] - e), 32'h1);
        check_val("t4_nwr", 32'(wr_cnt[0] - b), 32'h0);
        check_val("t4_addr", 32'(bus0.ram_addr), 32'h7FF);
        smp = '{16'd1, 16'd2, 16'd3, 16'd6};
        send_pkt(0, 8, 16'hA5, smp, 4);
        idle(0, 4);
        check_val("t4_nwr2", 32'(wr_cnt[0] - b), 32'h1);
        check_val("t4_addr2", 32'(wr_a[0][b]), 32'h7FF);
        check_val("t4_data2", 32'(wr_d[0][b]), 32'h03);

        // Header values inside a packet are plain data.
        b = wr_cnt[0];
        smp = '{16'hA5, 16'hA5, 16'hA5, 16'hA5};
        send_pkt(0, 8, 16'hA5, smp, 4);
        idle(0, 4);
        check_val("t5_nwr", 32'(wr_cnt[0] - b), 32'h1);
        check_val("t5_data", 32'(wr_d[0][b]), 32'hA5);
        check_val("t5_addr", 32'(wr_a[0][b]), 32'h7FE);

        // Single-sample packets on 4-bit words.
        b = wr_cnt[2];
        smp = '{16'h7, 16'h0, 16'h0, 16'h0};
        send_pkt(2, 4, 16'hA, smp, 1);
        idle(2, 4);
        check_val("t6_nwr", 32'(wr_cnt[2] - b), 32'h1);
        check_val("t6_data", 32'(wr_d[2][b]), 32'h7);
        check_val("t6_addr", 32'(wr_a[2][b]), 32'h7FF);

`ifdef TAS_CHECKSUM_EN
        // Good and bad checksum words.
        do_reset();
        b = wr_cnt[0];
        e = err_cnt[0];
        send_word(0, 8, 16'hA5);
        send_word(0, 8, 16'h01);
        send_word(0, 8, 16'h02);
        send_word(0, 8, 16'h03);
        send_word(0, 8, 16'h04);
        send_word(0, 8, 16'hAF);
        idle(0, 4);
        check_val("t7_nwr", 32'(wr_cnt[0] - b), 32'h1);
        check_val("t7_data", 32'(wr_d[0][b]), 32'h02);
        check_val("t7_nerr", 32'(err_cnt[0] - e), 32'h0);
        b = wr_cnt[0];
        send_word(0, 8, 16'hA5);
        send_word(0, 8, 16'h01);
        send_word(0, 8, 16'h02);
        send_word(0, 8, 16'h03);
        send_word(0, 8, 16'h04);
        send_word(0, 8, 16'hB0);
        idle(0, 4);
        check_val("t7_bad_nwr", 32'(wr_cnt[0] - b), 32'h0);
        check_val("t7_bad_nerr", 32'(err_cnt[0] - e), 32'h1);
        check_val("t7_bad_addr", 32'(bus0.ram_addr), 32'h7FE);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
